// File: rtl/waveform_buffer_reader.sv
`timescale 1ns/1ps
// Read side of the waveform buffer: pops a header, presents it downstream, then streams
// the waveform's samples from RAM through a 2-entry skid buffer with valid/ready flow control.
module waveform_buffer_reader #(
    parameter int P_DATA_WIDTH = 22,
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_HDR_WIDTH  = 80
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    hdr_empty,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data,
    output logic                    hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
    input  logic [P_DATA_WIDTH-1:0] wvb_data,
    output logic [P_HDR_WIDTH-1:0]  hdr_out,
    output logic                    hdr_out_valid,
    input  logic                    hdr_out_ready,
    output logic [P_DATA_WIDTH-1:0] dout,
    output logic                    dout_valid,
    output logic                    dout_last,
    input  logic                    dout_ready,
    output logic [P_ADR_WIDTH-1:0]  rd_ptr,
    output logic                    wvf_done,
    output logic                    eoe_err,
    output logic                    busy
);

    localparam logic [P_ADR_WIDTH-1:0] ADR_ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_POP, S_LATCH, S_HDR, S_DATA, S_DONE} state_t;

    state_t                  state_reg, state_next;
    logic                    hdr_rdreq_reg;
    logic [P_HDR_WIDTH-1:0]  hdr_reg;
    logic [P_ADR_WIDTH-1:0]  addr_reg;
    logic [P_ADR_WIDTH-1:0]  stop_reg;
    logic [P_ADR_WIDTH-1:0]  rd_ptr_reg;
    logic                    issue_done_reg;
    logic                    in_flight_reg;
    logic                    in_flight_last_reg;
    logic [P_DATA_WIDTH-1:0] skid_data_reg [2];
    logic                    skid_last_reg [2];
    logic                    wr_idx_reg;
    logic                    rd_idx_reg;
    logic [1:0]              skid_count_reg;

    logic       pop;
    logic       last_pop;
    logic       issue;
    logic [2:0] occupancy;

    assign dout_valid = (skid_count_reg != 2'd0);
    assign dout       = skid_data_reg[rd_idx_reg];
    assign dout_last  = dout_valid & skid_last_reg[rd_idx_reg];
    assign pop        = dout_valid & dout_ready;
    assign last_pop   = pop & dout_last;
    assign occupancy  = {1'b0, skid_count_reg} + {2'b00, in_flight_reg};

    // A word popped this cycle frees its slot in time for a read issued now, which
    // keeps one sample per cycle flowing while never overfilling the skid buffer.
    assign issue = (state_reg == S_DATA) && !issue_done_reg
                   && (occupancy < (3'd2 + {2'b00, pop}));

    assign hdr_rdreq     = hdr_rdreq_reg;
    assign wvb_rd_addr   = addr_reg;
    assign hdr_out       = hdr_reg;
    assign hdr_out_valid = (state_reg == S_HDR);
    assign rd_ptr        = rd_ptr_reg;
    assign wvf_done      = last_pop;
    assign eoe_err       = pop & (dout[0] != dout_last);
    assign busy          = (state_reg != S_IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (en && !hdr_empty) state_next = S_POP;
            S_POP:   state_next = S_LATCH;
            S_LATCH: state_next = S_HDR;
            S_HDR:   if (hdr_out_ready) state_next = S_DATA;
            S_DATA:  if (last_pop) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= S_IDLE;
            hdr_rdreq_reg      <= 1'b0;
            hdr_reg            <= '0;
            addr_reg           <= '0;
            stop_reg           <= '0;
            rd_ptr_reg         <= '0;
            issue_done_reg     <= 1'b0;
            in_flight_reg      <= 1'b0;
            in_flight_last_reg <= 1'b0;
            wr_idx_reg         <= 1'b0;
            rd_idx_reg         <= 1'b0;
            skid_count_reg     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                skid_data_reg[i] <= '0;
                skid_last_reg[i] <= 1'b0;
            end
        end else begin
            state_reg     <= state_next;
            hdr_rdreq_reg <= (state_reg == S_IDLE) && en && !hdr_empty;

            if (state_reg == S_LATCH) begin
                hdr_reg        <= hdr_data;
                addr_reg       <= hdr_data[P_ADR_WIDTH-1:0];
                stop_reg       <= hdr_data[2*P_ADR_WIDTH-1:P_ADR_WIDTH];
                issue_done_reg <= 1'b0;
            end

            if (issue) begin
                addr_reg <= addr_reg + ADR_ONE;
                if (addr_reg == stop_reg) issue_done_reg <= 1'b1;
            end
            in_flight_reg      <= issue;
            in_flight_last_reg <= issue && (addr_reg == stop_reg);

            // RAM output is valid the cycle after the address was presented.
            if (in_flight_reg) begin
                skid_data_reg[wr_idx_reg] <= wvb_data;
                skid_last_reg[wr_idx_reg] <= in_flight_last_reg;
                wr_idx_reg                <= ~wr_idx_reg;
            end
            if (pop) rd_idx_reg <= ~rd_idx_reg;
            skid_count_reg <= skid_count_reg + {1'b0, in_flight_reg} - {1'b0, pop};

            if (last_pop) rd_ptr_reg <= stop_reg + ADR_ONE;
        end
    end

endmodule

// File: tb/tb_waveform_buffer_reader.sv
`timescale 1ns/1ps
// Directed bench for waveform_buffer_reader with a header FIFO model and a waveform RAM model.
module tb_waveform_buffer_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        hdr_empty;
    logic [79:0] hdr_data;
    logic        hdr_rdreq;
    logic [11:0] wvb_rd_addr;
    logic [21:0] wvb_data;
    logic [79:0] hdr_out;
    logic        hdr_out_valid;
    logic        hdr_out_ready;
    logic [21:0] dout;
    logic        dout_valid;
    logic        dout_last;
    logic        dout_ready;
    logic [11:0] rd_ptr;
    logic        wvf_done;
    logic        eoe_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int rdreq_count = 0;

    logic [21:0] ram [4096];
    logic [79:0] fifo_mem [8];
    int fifo_wr = 0;
    int fifo_rd = 0;

    always #5 clk = ~clk;

    waveform_buffer_reader dut (
        .clk(clk), .rst(rst), .en(en), .hdr_empty(hdr_empty), .hdr_data(hdr_data),
        .hdr_rdreq(hdr_rdreq), .wvb_rd_addr(wvb_rd_addr), .wvb_data(wvb_data),
        .hdr_out(hdr_out), .hdr_out_valid(hdr_out_valid), .hdr_out_ready(hdr_out_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
        .rd_ptr(rd_ptr), .wvf_done(wvf_done), .eoe_err(eoe_err), .busy(busy)
    );

    assign hdr_empty = (fifo_wr == fifo_rd);

    always @(posedge clk) begin
        wvb_data <= ram[wvb_rd_addr];
        if (hdr_rdreq) rdreq_count <= rdreq_count + 1;
        if (hdr_rdreq && (fifo_rd != fifo_wr)) begin
            hdr_data <= fifo_mem[fifo_rd % 8];
            fifo_rd  <= fifo_rd + 1;
        end
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] mk_hdr(input int tno, input logic [11:0] start, input logic [11:0] stop);
        return {8'(tno), 48'hC0DE_1234_5678, stop, start};
    endfunction

    task automatic push_hdr(input logic [79:0] h);
        fifo_mem[fifo_wr % 8] = h;
        fifo_wr++;
    endtask

    // Runs one waveform end to end; abort_after>0 returns right after that many samples.
    task automatic run_wave(input int tno, input logic [11:0] start, input logic [11:0] stop,
                            input bit rnd, input bit do_push, input int abort_after);
        logic [79:0] h;
        logic [11:0] a;
        logic [21:0] prev_d;
        logic        prev_l;
        bit          prev_stall;
        bit          exp_last;
        int          len, k, cyc, first_c, last_c, rq0;
        h          = mk_hdr(tno, start, stop);
        len        = int'(12'(stop - start)) + 1;
        rq0        = rdreq_count;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        hdr_out_ready = 1'b0;
        dout_ready    = 1'b0;
        if (do_push) push_hdr(h);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (hdr_out_valid) break;
        end
        chk($sformatf("t%0d_hdr_valid", tno), 80'(hdr_out_valid), 80'(1));
        chk($sformatf("t%0d_hdr_out", tno), hdr_out, h);
        chk($sformatf("t%0d_no_early_data", tno), 80'(dout_valid), 80'(0));
        chk($sformatf("t%0d_rdreq_pulses", tno), 80'(rdreq_count - rq0), 80'(1));
        repeat (2) begin
            @(negedge clk); #1;
            chk($sformatf("t%0d_hdr_hold", tno), 80'(hdr_out_valid), 80'(1));
        end
        hdr_out_ready = 1'b1;
        @(negedge clk);
        hdr_out_ready = 1'b0;

        k = 0; cyc = 0; first_c = -1; last_c = 0;
        while (k < len && cyc < 400) begin
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) begin
                chk($sformatf("t%0d_stall_valid", tno), 80'(dout_valid), 80'(1));
                chk($sformatf("t%0d_stall_data", tno), 80'(dout), 80'(prev_d));
                chk($sformatf("t%0d_stall_last", tno), 80'(dout_last), 80'(prev_l));
            end
            if (dout_valid && dout_ready) begin
                a        = start + 12'(k);
                exp_last = (k == len - 1);
                chk($sformatf("t%0d_word%0d", tno, k), 80'(dout), 80'(ram[a]));
                chk($sformatf("t%0d_last%0d", tno, k), 80'(dout_last), 80'(exp_last));
                chk($sformatf("t%0d_done%0d", tno, k), 80'(wvf_done), 80'(exp_last));
                chk($sformatf("t%0d_eoe%0d", tno, k), 80'(eoe_err), 80'(ram[a][0] != exp_last));
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                k++;
                if (abort_after != 0 && k == abort_after) break;
            end else begin
                chk($sformatf("t%0d_done_idle", tno), 80'(wvf_done), 80'(0));
            end
            prev_stall = dout_valid && !dout_ready;
            prev_d     = dout;
            prev_l     = dout_last;
            cyc++;
            @(negedge clk);
        end
        if (abort_after != 0) begin
            chk($sformatf("t%0d_abort_count", tno), 80'(k), 80'(abort_after));
            return;
        end
        chk($sformatf("t%0d_count", tno), 80'(k), 80'(len));
        if (!rnd) chk($sformatf("t%0d_gapless", tno), 80'(last_c - first_c), 80'(len - 1));
        dout_ready = 1'b0;
        #1;
        chk($sformatf("t%0d_rd_ptr", tno), 80'(rd_ptr), 80'(12'(stop + 12'd1)));
        chk($sformatf("t%0d_after_valid", tno), 80'(dout_valid), 80'(0));
        chk($sformatf("t%0d_done_busy", tno), 80'(busy), 80'(1));
        @(negedge clk); #1;
        chk($sformatf("t%0d_idle", tno), 80'(busy), 80'(0));
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) ram[a] = {2'b10, 12'(a), 7'h33, 1'b0};
        ram[13][0]  = 1'b1;
        ram[1][0]   = 1'b1;
        ram[7][0]   = 1'b1;
        ram[119][0] = 1'b1;
        ram[201][0] = 1'b1;
        ram[309][0] = 1'b1;
        ram[505][0] = 1'b1;

        rst = 1'b1; en = 1'b1; hdr_out_ready = 1'b0; dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hdr_rdreq", 80'(hdr_rdreq), 80'(0));
        chk("rst_hdr_valid", 80'(hdr_out_valid), 80'(0));
        chk("rst_hdr_out", hdr_out, 80'(0));
        chk("rst_dout_valid", 80'(dout_valid), 80'(0));
        chk("rst_dout", 80'(dout), 80'(0));
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_rd_ptr", 80'(rd_ptr), 80'(0));
        chk("rst_wvf_done", 80'(wvf_done), 80'(0));
        rst = 1'b0;

        run_wave(1, 12'd10, 12'd13, 1'b0, 1'b1, 0);
        run_wave(2, 12'd4094, 12'd1, 1'b0, 1'b1, 0);
        run_wave(3, 12'd7, 12'd7, 1'b0, 1'b1, 0);
        run_wave(4, 12'd100, 12'd119, 1'b1, 1'b1, 0);
        run_wave(5, 12'd200, 12'd204, 1'b0, 1'b1, 0);

        run_wave(6, 12'd300, 12'd309, 1'b0, 1'b1, 3);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t6_rst_dout_valid", 80'(dout_valid), 80'(0));
        chk("t6_rst_dout", 80'(dout), 80'(0));
        chk("t6_rst_busy", 80'(busy), 80'(0));
        chk("t6_rst_rd_ptr", 80'(rd_ptr), 80'(0));
        chk("t6_rst_hdr_out", hdr_out, 80'(0));
        chk("t6_rst_hdr_valid", 80'(hdr_out_valid), 80'(0));
        rst = 1'b0;
        dout_ready = 1'b0;

        en = 1'b0;
        begin
            int rq0;
            rq0 = rdreq_count;
            push_hdr(mk_hdr(7, 12'd500, 12'd505));
            repeat (6) @(negedge clk);
            #1;
            chk("en_low_no_pop", 80'(rdreq_count - rq0), 80'(0));
            chk("en_low_idle", 80'(busy), 80'(0));
        end
        en = 1'b1;
        run_wave(7, 12'd500, 12'd505, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
